// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues in-order IMEM word fetches and queues
// returned words with their PCs for decode. Optional build macro: IFU_MISALIGN_TRAP_EN.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        fetch_misaligned
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    logic [31:0]            fetch_pc_r;
    logic [31:0]            q_data_r [QUEUE_DEPTH];
    logic [31:0]            q_pc_r   [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] q_filled_r;
    logic [AW-1:0]          head_r;
    logic [AW-1:0]          tail_r;
    logic [AW-1:0]          fill_r;
    logic [CW-1:0]          count_r;   // reserved slots, filled or still in flight
    logic [CW-1:0]          outst_r;   // reserved slots still waiting for IMEM
    logic [7:0]             drop_cnt_r;

    logic        misaligned_s;
    logic [31:0] redirect_tgt_s;
    logic        req_fire_s;
    logic        pop_s;
    logic        fill_s;

`ifdef IFU_MISALIGN_TRAP_EN
    logic misaligned_r;

    // Trap flag follows the alignment of the most recent redirect target.
    always_ff @(posedge clk) begin
        if (rst) begin
            misaligned_r <= 1'b0;
        end else if (redirect_valid) begin
            misaligned_r <= (redirect_pc[1:0] != 2'b00);
        end else begin
            misaligned_r <= misaligned_r;
        end
    end

    assign misaligned_s     = misaligned_r;
    assign fetch_misaligned = misaligned_r;
    assign redirect_tgt_s   = redirect_pc;
`else
    assign misaligned_s     = 1'b0;
    assign fetch_misaligned = 1'b0;
    assign redirect_tgt_s   = redirect_pc & 32'hFFFF_FFFC;
`endif

    // Request/handshake decode; head outputs read straight from queue registers.
    always_comb begin
        imem_req_valid = 1'b0;
        inst_valid     = q_filled_r[head_r];
        inst           = 32'h0000_0000;
        inst_pc        = 32'h0000_0000;
        if (!rst && !redirect_valid && !misaligned_s && (count_r < DEPTH_C)) begin
            imem_req_valid = 1'b1;
        end else begin
            imem_req_valid = 1'b0;
        end
        if (inst_valid) begin
            inst    = q_data_r[head_r];
            inst_pc = q_pc_r[head_r];
        end else begin
            inst    = 32'h0000_0000;
            inst_pc = 32'h0000_0000;
        end
        imem_req_addr = fetch_pc_r;
        req_fire_s    = imem_req_valid & imem_req_ready;
        pop_s         = inst_valid & inst_ready;
        fill_s        = imem_rsp_valid && (drop_cnt_r == 8'd0);
    end

    // PC, queue and in-flight bookkeeping; redirect overrides everything but reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            q_filled_r <= '0;
            head_r     <= '0;
            tail_r     <= '0;
            fill_r     <= '0;
            count_r    <= '0;
            outst_r    <= '0;
            drop_cnt_r <= 8'd0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_data_r[i] <= 32'h0000_0000;
                q_pc_r[i]   <= 32'h0000_0000;
            end
        end else if (redirect_valid) begin
            fetch_pc_r <= redirect_tgt_s;
            q_filled_r <= '0;
            head_r     <= '0;
            tail_r     <= '0;
            fill_r     <= '0;
            count_r    <= '0;
            outst_r    <= '0;
            // Whatever is still in flight (minus this cycle's word) must be discarded.
            drop_cnt_r <= drop_cnt_r + 8'(outst_r) - 8'(imem_rsp_valid);
        end else begin
            if (req_fire_s) begin
                q_pc_r[tail_r] <= fetch_pc_r;
                tail_r         <= tail_r + AW'(1'b1);
                fetch_pc_r     <= fetch_pc_r + 32'd4;
            end else begin
                tail_r     <= tail_r;
                fetch_pc_r <= fetch_pc_r;
            end
            if (imem_rsp_valid && (drop_cnt_r != 8'd0)) begin
                drop_cnt_r <= drop_cnt_r - 8'd1;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
            if (fill_s) begin
                q_data_r[fill_r]   <= imem_rsp_data;
                q_filled_r[fill_r] <= 1'b1;
                fill_r             <= fill_r + AW'(1'b1);
            end else begin
                fill_r <= fill_r;
            end
            if (pop_s) begin
                q_filled_r[head_r] <= 1'b0;
                head_r             <= head_r + AW'(1'b1);
            end else begin
                head_r <= head_r;
            end
            count_r <= count_r + CW'(req_fire_s) - CW'(pop_s);
            outst_r <= outst_r + CW'(req_fire_s) - CW'(fill_s);
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: in-order IMEM model, PC-stream scoreboard checked every
// cycle, plus directed scenarios with literal expectations.
module tb_inst_fetch_unit;
    localparam int QD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        fetch_misaligned;

    inst_fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .inst_ready(inst_ready), .fetch_misaligned(fetch_misaligned)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int lat    = 1;
    int cyc    = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] acc_log[$];

    // Model state: next request PC, next PC decode must see, slots in use.
    logic [31:0] m_req_pc;
    logic [31:0] m_inst_pc;
    int          m_slots;
    bit          m_mis;
    bit          hold_pend;
    logic [31:0] hold_inst;
    logic [31:0] hold_pc;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    // IMEM: in-order, one word per cycle, fixed latency after acceptance.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0000_0000;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                logic [31:0] a;
                int d;
                a = pend_addr.pop_front();
                d = pend_due.pop_front();
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = word_of(a);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
        end
    end

    // Scoreboard: checks outputs each cycle, then advances the model by this cycle's events.
    always @(negedge clk) begin
        if (rst) begin
            m_req_pc  = 32'h0000_0000;
            m_inst_pc = 32'h0000_0000;
            m_slots   = 0;
            m_mis     = 1'b0;
            hold_pend = 1'b0;
            pend_addr.delete();
            pend_due.delete();
        end else begin
            if (hold_pend) begin
                chk("hold_valid", 32'(inst_valid), 32'd1);
                chk("hold_inst", inst, hold_inst);
                chk("hold_pc", inst_pc, hold_pc);
            end
            if (!inst_valid) begin
                chk("idle_inst", inst, 32'h0000_0000);
                chk("idle_pc", inst_pc, 32'h0000_0000);
            end
            chk("req_valid", 32'(imem_req_valid), 32'(!redirect_valid && m_slots < QD && !m_mis));
            if (imem_req_valid) chk("req_addr", imem_req_addr, m_req_pc);
            chk("misaligned", 32'(fetch_misaligned), 32'(m_mis));
            if (inst_valid && inst_ready) begin
                chk("inst_pc", inst_pc, m_inst_pc);
                chk("inst", inst, word_of(m_inst_pc));
                m_inst_pc = m_inst_pc + 32'd4;
                m_slots--;
            end
            if (imem_req_valid && imem_req_ready) begin
                pend_addr.push_back(imem_req_addr);
                pend_due.push_back(cyc + lat);
                acc_log.push_back(imem_req_addr);
                m_req_pc = m_req_pc + 32'd4;
                m_slots++;
            end
            hold_pend = inst_valid && !inst_ready && !redirect_valid;
            hold_inst = inst;
            hold_pc   = inst_pc;
            if (redirect_valid) begin
`ifdef IFU_MISALIGN_TRAP_EN
                m_mis     = (redirect_pc[1:0] != 2'b00);
                m_req_pc  = redirect_pc;
`else
                m_req_pc  = {redirect_pc[31:2], 2'b00};
`endif
                m_inst_pc = m_req_pc;
                m_slots   = 0;
            end
        end
    end

    initial begin
        int base;
        bit found;
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        inst_ready     = 1'b1;

        // Reset values
        tick();
        tick();
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'h0000_0000);
        chk("rst_inst_pc", inst_pc, 32'h0000_0000);
        chk("rst_misaligned", 32'(fetch_misaligned), 32'd0);

        // Streaming at 1-cycle latency: first word visible the cycle after its response
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("c0_req_valid", 32'(imem_req_valid), 32'd1);
        chk("c0_req_addr", imem_req_addr, 32'h0000_0000);
        tick();
        @(negedge clk);
        chk("c1_inst_valid", 32'(inst_valid), 32'd0);
        chk("c1_req_addr", imem_req_addr, 32'h0000_0004);
        tick();
        @(negedge clk);
        chk("c2_inst_valid", 32'(inst_valid), 32'd1);
        chk("c2_inst_pc", inst_pc, 32'h0000_0000);
        chk("c2_inst", inst, 32'h1357_6420);
        repeat (15) tick();

        // Backpressure from reset: only QD fetches accepted, then resume in order
        rst = 1'b1;
        tick();
        tick();
        rst        = 1'b0;
        inst_ready = 1'b0;
        base       = acc_log.size();
        repeat (10) tick();
        @(negedge clk);
        chk("bp_acc_cnt", 32'(acc_log.size() - base), 32'd2);
        if (acc_log.size() >= base + 2) begin
            chk("bp_acc0", acc_log[base], 32'h0000_0000);
            chk("bp_acc1", acc_log[base+1], 32'h0000_0004);
        end
        chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
        chk("bp_inst_pc", inst_pc, 32'h0000_0000);
        tick();
        inst_ready = 1'b1;
        repeat (10) tick();
        chk("bp_resume_cnt", 32'(acc_log.size() >= base + 3), 32'd1);
        if (acc_log.size() >= base + 3) chk("bp_acc2", acc_log[base+2], 32'h0000_0008);

        // 3-cycle latency, redirect with both fetches in flight
        lat        = 3;
        inst_ready = 1'b0;
        redirect(32'h0000_0040);
        tick();
        redirect(32'h0000_0100);
        inst_ready = 1'b1;
        for (int i = 0; i < 30 && !inst_valid; i++) tick();
        chk("lat3_wait_valid", 32'(inst_valid), 32'd1);
        chk("lat3_inst_pc", inst_pc, 32'h0000_0100);
        chk("lat3_inst", inst, 32'h1257_6520);
        lat = 1;
        repeat (8) tick();

        // Redirect coinciding with a response and a head transfer
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (imem_rsp_valid && inst_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("coinc_found", 32'(found), 32'd1);
        if (found) begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'h0000_0300;
            tick();
            redirect_valid = 1'b0;
            @(negedge clk);
            chk("coinc_inst_valid", 32'(inst_valid), 32'd0);
            chk("coinc_req_valid", 32'(imem_req_valid), 32'd1);
            chk("coinc_req_addr", imem_req_addr, 32'h0000_0300);
        end
        repeat (10) tick();

        // 32-bit PC wrap
        base = acc_log.size();
        redirect(32'hFFFF_FFF8);
        repeat (10) tick();
        chk("wrap_cnt", 32'(acc_log.size() >= base + 3), 32'd1);
        if (acc_log.size() >= base + 3) begin
            chk("wrap_acc0", acc_log[base], 32'hFFFF_FFF8);
            chk("wrap_acc1", acc_log[base+1], 32'hFFFF_FFFC);
            chk("wrap_acc2", acc_log[base+2], 32'h0000_0000);
        end

        // Misaligned redirect target
        redirect(32'h0000_0102);
        @(negedge clk);
`ifdef IFU_MISALIGN_TRAP_EN
        chk("mis_flag", 32'(fetch_misaligned), 32'd1);
        chk("mis_req_valid", 32'(imem_req_valid), 32'd0);
        repeat (3) tick();
        @(negedge clk);
        chk("mis_stall", 32'(imem_req_valid), 32'd0);
        chk("mis_inst_valid", 32'(inst_valid), 32'd0);
        tick();
        redirect(32'h0000_0200);
        @(negedge clk);
        chk("mis_clear", 32'(fetch_misaligned), 32'd0);
        chk("mis_resume_valid", 32'(imem_req_valid), 32'd1);
        chk("mis_resume_addr", imem_req_addr, 32'h0000_0200);
`else
        chk("align_req_valid", 32'(imem_req_valid), 32'd1);
        chk("align_req_addr", imem_req_addr, 32'h0000_0100);
        chk("align_flag", 32'(fetch_misaligned), 32'd0);
`endif
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch stage directly upstream of decode and immediate generation.
- Owns the PC register and issues in-order word fetches to instruction memory over a valid/ready request port.
- Buffers returned instruction words, each with its PC, in a small queue.
- Presents the 32-bit instruction word and its PC to decode over a valid/ready handshake. Branch/jump redirects flush all in-flight and buffered work.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- QUEUE_DEPTH, 2, instruction queue entries; power of two, >= 2; also the cap on outstanding plus buffered fetches.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  IMEM accepts request this cycle
- imem_req_addr  out  32  word address of request (fetch_pc)
- imem_rsp_valid  in  1  IMEM returns one word (in order, >= 1 cycle after acceptance)
- imem_rsp_data  in  32  returned instruction word
- redirect_valid  in  1  branch/jump taken; restart fetch
- redirect_pc  in  32  new fetch address
- inst_valid  out  1  head queue entry available to decode
- inst  out  32  instruction word to decode / immediate generator
- inst_pc  out  32  PC of inst
- inst_ready  in  1  decode consumes head this cycle
- fetch_misaligned  out  1  only with IFU_MISALIGN_TRAP_EN

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - fetch_pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0.
  - imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, fetch_misaligned=0.
  - IMEM shares rst, so no pre-reset responses arrive.
- Request issue:
  - imem_req_valid=1 when !rst && !redirect_valid && (occupancy + outstanding) < QUEUE_DEPTH.
  - Accept = valid & ready. On accept: reserve the tail slot, tagged with fetch_pc; outstanding+1; fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0).
  - Address held stable while valid && !ready, except in a redirect cycle.
  - IMEM tolerates request withdrawal.
- Response:
  - If drop_cnt>0: discard the word, drop_cnt-1.
  - Else: write data into the oldest reserved slot, mark it filled, outstanding-1.
  - Max one response per cycle.
- Output:
  - inst_valid = head slot filled. inst/inst_pc come from queue registers (no combinational path from imem_rsp_data).
  - Response in cycle N -> inst_valid in cycle N+1.
  - inst/inst_pc hold while inst_valid && !inst_ready. inst and inst_pc are 0 when the queue is empty.
- Transfer = inst_valid & inst_ready: pop head.
- Full: no request while occupancy + outstanding == QUEUE_DEPTH. A same-cycle pop frees a slot for the next cycle, not the same cycle.
- Empty: inst_valid=0; inst_ready ignored.
- Simultaneous response + pop on the same entry is impossible (fill visible next cycle). Response + pop on different entries are both performed.
- Redirect, highest priority:
  - fetch_pc <= redirect_pc; queue cleared; imem_req_valid=0 that cycle.
  - drop_cnt <= drop_cnt + outstanding − (1 if a response arrives this cycle); outstanding <= 0.
  - Any head transfer in the same cycle counts as consumed.
  - The first request to redirect_pc goes out the next cycle.
  - Back-to-back redirects: the last one wins; drop_cnt keeps accumulating.
- While drop_cnt>0, new requests may issue. Responses stay in order, so discards always precede new fills.

Optional Feature:
- Macro: IFU_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets fetch_misaligned=1 (registered, next cycle) and stalls all requests.
  - fetch_misaligned holds until the next aligned redirect or rst. inst_valid stays 0 meanwhile.
- Undefined:
  - Port tied 0.
  - redirect_pc[1:0] forced to 00 before loading fetch_pc.

Test Plan:
- Reset then imem_req_ready=1, 1-cycle IMEM latency, inst_ready=1 -> addrs 0x0, 0x4, 0x8…; inst_pc 0x0 with first word one cycle after its response; sustained 1 instr/cycle.
- inst_ready=0 for 10 cycles -> exactly QUEUE_DEPTH(2) requests accepted, then imem_req_valid=0; inst/inst_pc stable. Release -> words 0x0, 0x4 delivered in order, fetching resumes at 0x8.
- 3-cycle IMEM latency with 2 outstanding, redirect_pc=0x100 -> both stale responses dropped; next inst_pc=0x100 with the 0x100 data; no stale word ever at inst_valid.
- Redirect in the same cycle as an IMEM response and an inst transfer -> drop_cnt excludes that response; queue empty next cycle; request to the new PC next cycle.
- fetch_pc=0xFFFF_FFFC -> next request addr 0x0000_0000.
- With IFU_MISALIGN_TRAP_EN: redirect_pc=0x102 -> fetch_misaligned=1 next cycle, no requests. Redirect 0x200 -> flag clears, fetch resumes at 0x200. Without the macro: redirect 0x102 fetches 0x100.
